fifo_reader: RTL and testbench
==============================

# fifo_reader

Read-side controller for the team's synchronous `fifo` (`dwidth`/`awidth` parameterised, `rd_en`/`data_out`/`empty` read port). It drains the FIFO and presents its words on a valid/ready stream, keeping full throughput despite the FIFO's one-cycle read latency. A two-entry skid buffer decouples downstream backpressure from `rd_en` timing. It sits between `fifo` and any consumer that expects a stream handshake rather than a raw pop strobe.

## Interface
- `dwidth`, default 5: word width; must match the attached `fifo`.
- `clk`  in  1  rising-edge clock shared with `fifo`.
- `rst`  in  1  asynchronous, active-high reset.
- `fifo_data`  in  dwidth  `fifo.data_out`; holds the popped word in the cycle after `fifo_rd_en` was high.
- `fifo_empty`  in  1  `fifo.empty`.
- `fifo_rd_en`  out  1  pop strobe to `fifo.rd_en` (combinational).
- `flush`  in  1  synchronous discard of all buffered and in-flight words.
- `m_data`  out  dwidth  output word (head of skid buffer).
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  consumer accepts `m_data` this cycle.
- `rd_count`  out  32  words delivered (only with `FIFO_READER_CNT_EN`).

## Operation
- Buffer states: `EMPTY` (occ 0), `ONE` (occ 1, slot0 valid), `TWO` (occ 2, slot0 + slot1 valid). `m_valid = (state != EMPTY)`; `m_data = slot0`.
- `pop = m_valid & m_ready`. `inflight` register = `fifo_rd_en` of the previous cycle.
- `fifo_rd_en = !rst & !flush & !fifo_empty & (occ + inflight - pop < 2)`.
- Arrival (`inflight` = 1): `fifo_data` goes to slot0 if the buffer is empty after this cycle's pop, else to slot1.
- Pop in `TWO`: slot1 shifts to slot0. Simultaneous pop and arrival in `ONE`: slot0 takes `fifo_data`; state stays `ONE`.
- Transitions: `EMPTY`→`ONE` on arrival. `ONE`→`TWO` on arrival without pop. `ONE`→`EMPTY` on pop without arrival. `TWO`→`ONE` on pop; arrival in `TWO` cannot happen by construction (assertion).
- Order is strictly FIFO; no word is duplicated or dropped except by `flush`.
- `flush`: the next state is `EMPTY`, `inflight` is cleared, and a word arriving in the flush cycle is discarded. `pop` is still honoured for counting, and `m_valid` is unchanged during the flush cycle itself.
- Upstream `fifo_empty` is trusted; the block never pops when `fifo_empty` = 1.

## Timing
- Reset values: `m_valid` = 0, `m_data` = 0, `fifo_rd_en` = 0, `inflight` = 0, state `EMPTY`, `rd_count` = 0. Reset is asynchronous on assertion. Deasserting `rst` mid-transfer loses the in-flight word; the `fifo` must be reset together with this block.
- Latency: `fifo_rd_en` high in cycle t → `m_valid` high in cycle t+2 (FIFO registers in t, capture at end of t+1).
- Throughput: 1 word/cycle sustained while `fifo_empty` = 0 and `m_ready` = 1.
- Backpressure: after `m_ready` falls, at most one further pop is issued. The skid absorbs it, and `fifo_rd_en` stays 0 until a pop frees a slot.
- `m_data`/`m_valid` are stable while `m_valid` = 1 and `m_ready` = 0.

## Configuration
- `FIFO_READER_CNT_EN` defined: `rd_count` exists and increments by 1 on every `pop`, wrapping at 2^32. It is not cleared by `flush`; it is cleared by `rst`.
- `FIFO_READER_CNT_EN` undefined: the `rd_count` port and counter are absent; all other behaviour is identical.

## Structure
- `fifo_pkg`: state encodings `ST_EMPTY`/`ST_ONE`/`ST_TWO` and the default `dwidth`/`awidth` constants shared with `fifo`.
- Sub-module `fifo_reader_skid` holds the 2-entry buffer, occupancy state and shift logic. The top contains the `inflight`/`fifo_rd_en` logic, `flush` handling and the optional counter.

## Test plan
- Reset mid-stream with `fifo_rd_en` high → all outputs 0 immediately, before the next clock edge.
- `fifo` holds 31,30,29, `m_ready` = 1 → `m_data` = 31,30,29 on consecutive cycles starting 2 cycles after the first `fifo_rd_en`; `m_valid` drops after 29.
- Fill the `fifo` to full (256 words, counting down from 31 with wrap), `m_ready` = 1 → 256 words out in order, 1/cycle, no gaps; with `FIFO_READER_CNT_EN`, `rd_count` = 256.
- Stream running, `m_ready` low for 5 cycles → `m_data` held constant, exactly one extra pop absorbed (state `TWO`), no word lost on resume.
- `flush` asserted with occ = 2 and a word in flight → next cycle `m_valid` = 0; the next word out is the FIFO's next unpopped word.
- `fifo_empty` = 1 at all times, `m_ready` toggling → `fifo_rd_en` never asserted, `m_valid` stays 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Constants and skid-buffer state encoding shared by fifo and fifo_reader.
// The optional fifo_reader counter is selected with FIFO_READER_CNT_EN.
package fifo_pkg;

    localparam int DWIDTH = 5;
    localparam int AWIDTH = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    // Number of valid skid slots represented by a state.
    function automatic logic [1:0] state_occ(input skid_state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            ST_ONE:  occ = 2'd1;
            ST_TWO:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus output stream of fifo_reader; master = the reader side.
// Optional rd_count (FIFO_READER_CNT_EN) stays a plain port on fifo_reader.
interface fifo_reader_if #(
    parameter int dwidth = fifo_pkg::DWIDTH
);
    logic [dwidth-1:0] fifo_data;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [dwidth-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    // Stream handshake: a word transfers on every rising edge where m_valid && m_ready;
    // once m_valid is high, m_data and m_valid hold until that transfer (flush excepted).
    modport master (
        input  fifo_data,
        input  fifo_empty,
        input  m_ready,
        output fifo_rd_en,
        output m_data,
        output m_valid
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        output m_ready,
        input  fifo_rd_en,
        input  m_data,
        input  m_valid
    );
endinterface

// File: rtl/fifo_reader_skid.sv
// Two-entry skid buffer for fifo_reader: occupancy FSM, slot capture and shift.
// Unaffected by FIFO_READER_CNT_EN.
module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int dwidth = DWIDTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_pop,
    input  logic              i_arrive,
    input  logic [dwidth-1:0] i_data,
    output logic [1:0]        o_occ,
    output logic              o_valid,
    output logic [dwidth-1:0] o_data,
    output skid_state_t       o_state
);

    skid_state_t       r_state;
    skid_state_t       w_state_nxt;
    logic [dwidth-1:0] r_slot0;
    logic [dwidth-1:0] r_slot1;
    logic [dwidth-1:0] w_slot0_nxt;
    logic [dwidth-1:0] w_slot1_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_EMPTY;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_slot0 <= w_slot0_nxt;
            r_slot1 <= w_slot1_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_slot0_nxt = r_slot0;
        w_slot1_nxt = r_slot1;
        case (r_state)
            ST_EMPTY: begin
                if (i_arrive) begin
                    w_slot0_nxt = i_data;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                // Pop and arrival together: the new word replaces the departing head.
                if (i_arrive) begin
                    if (i_pop) begin
                        w_slot0_nxt = i_data;
                    end else begin
                        w_slot1_nxt = i_data;
                        w_state_nxt = ST_TWO;
                    end
                end else if (i_pop) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (i_pop) begin
                    w_slot0_nxt = r_slot1;
                    w_state_nxt = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (i_flush) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    assign o_occ   = state_occ(r_state);
    assign o_valid = (r_state != ST_EMPTY);
    assign o_data  = r_slot0;
    assign o_state = r_state;

    // The read-enable throttle keeps occupancy plus in-flight words at two or less.
    a_no_arrive_in_two: assert property (
        @(posedge i_clk) disable iff (i_rst) !((r_state == ST_TWO) && i_arrive)
    );

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller draining a one-cycle-latency fifo onto a valid/ready stream.
// Define FIFO_READER_CNT_EN to add the 32-bit delivered-word counter rd_count.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int dwidth = DWIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    fifo_reader_if.master bus,
    output skid_state_t  o_dbg_state
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [31:0]  rd_count
`endif
);

    logic              r_inflight;
    logic              w_pop;
    logic              w_arrive;
    logic              w_rd_en;
    logic              w_valid;
    logic [1:0]        w_occ;
    logic [2:0]        w_committed;
    logic [dwidth-1:0] w_data;

    assign w_pop = w_valid & bus.m_ready;

    // Slots that will be spoken for after this edge, counting the word still in the fifo pipeline.
    assign w_committed = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en     = !rst && !flush && !bus.fifo_empty && (w_committed < 3'd2);
    assign w_arrive    = r_inflight && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
        end
    end

    fifo_reader_skid #(
        .dwidth(dwidth)
    ) u_skid (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_flush  (flush),
        .i_pop    (w_pop),
        .i_arrive (w_arrive),
        .i_data   (bus.fifo_data),
        .o_occ    (w_occ),
        .o_valid  (w_valid),
        .o_data   (w_data),
        .o_state  (o_dbg_state)
    );

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = w_valid;
    assign bus.m_data     = w_data;

`ifdef FIFO_READER_CNT_EN
    logic [31:0] r_rd_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_count <= '0;
        end else if (w_pop) begin
            r_rd_count <= r_rd_count + 32'd1;
        end
    end

    assign rd_count = r_rd_count;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: queue-based fifo plant, word-order/latency model and directed scenarios.
// Builds with or without FIFO_READER_CNT_EN.
module tb_fifo_reader;
    import fifo_pkg::*;

    localparam int W = DWIDTH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    fifo_reader_if #(.dwidth(W)) bus ();
    skid_state_t dbg_state;
`ifdef FIFO_READER_CNT_EN
    logic [31:0] rd_count;
`endif

    fifo_reader #(.dwidth(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus),
        .o_dbg_state (dbg_state)
`ifdef FIFO_READER_CNT_EN
        ,
        .rd_count    (rd_count)
`endif
    );

    // ---------------- fifo plant ----------------
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] pend_q[$];

    always @(posedge clk) begin
        if (bus.fifo_rd_en && fifo_q.size() > 0) bus.fifo_data <= fifo_q.pop_front();
        while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
        bus.fifo_empty <= (fifo_q.size() == 0);
    end

    // ---------------- scoreboard ----------------
    int n_pass = 0;
    int n_checks = 0;
    int unsigned cyc = 0;
    logic [W-1:0] exp_q[$];
    int unsigned stamp_q[$];
    logic [W-1:0] got_q[$];
    int unsigned got_cyc_q[$];
    int unsigned rd_cyc_q[$];
    int unsigned n_deliv = 0;
    logic prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    always @(negedge clk) begin
        logic exp_valid;
        logic pop_exp;
        logic rd_exp;
        cyc++;
        if (rst) begin
            exp_q.delete();
            stamp_q.delete();
            n_deliv = 0;
            prev_stall = 1'b0;
        end else begin
            // A word popped in cycle t is presented from cycle t+2 until taken.
            exp_valid = (stamp_q.size() > 0) && (stamp_q[0] + 2 <= cyc);
            pop_exp   = exp_valid && bus.m_ready;
            rd_exp    = !flush && !bus.fifo_empty && ((exp_q.size() - int'(pop_exp)) < 2);
            check("m_valid", 32'(bus.m_valid), 32'(exp_valid));
            if (exp_valid) check("m_data", 32'(bus.m_data), 32'(exp_q[0]));
            check("fifo_rd_en", 32'(bus.fifo_rd_en), 32'(rd_exp));
            if (prev_stall) check("stall_hold", 32'(bus.m_data), 32'(prev_data));
`ifdef FIFO_READER_CNT_EN
            check("rd_count", rd_count, n_deliv);
`endif
            prev_stall = exp_valid && !bus.m_ready && !flush;
            prev_data  = bus.m_data;
            if (pop_exp) begin
                got_q.push_back(exp_q.pop_front());
                void'(stamp_q.pop_front());
                got_cyc_q.push_back(cyc);
                n_deliv++;
            end
            if (flush) begin
                exp_q.delete();
                stamp_q.delete();
            end
            if (bus.fifo_rd_en && fifo_q.size() > 0) begin
                exp_q.push_back(fifo_q[0]);
                stamp_q.push_back(cyc);
                rd_cyc_q.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] v);
        pend_q.push_back(v);
    endtask

    task automatic wait_got(input int n, input int budget, input string name);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, 32'(got_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((fifo_q.size() > 0 || exp_q.size() > 0 || pend_q.size() > 0) && k < budget) begin
            tick();
            k++;
        end
        check("drain_timeout", 32'(k < budget), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int s;
        int gaps;
        logic [W-1:0] sd;

        rst = 1'b1;
        flush = 1'b0;
        bus.m_ready = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data = '0;
        tick();
        tick();
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
        check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_EMPTY));
`ifdef FIFO_READER_CNT_EN
        check("rst_rd_count", rd_count, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Three words, consumer always ready.
        got_q.delete();
        got_cyc_q.delete();
        rd_cyc_q.delete();
        bus.m_ready = 1'b1;
        push_word(5'd31);
        push_word(5'd30);
        push_word(5'd29);
        wait_got(3, 20, "t1_timeout");
        if (got_q.size() >= 3) begin
            check("t1_w0", 32'(got_q[0]), 32'd31);
            check("t1_w1", 32'(got_q[1]), 32'd30);
            check("t1_w2", 32'(got_q[2]), 32'd29);
            check("t1_latency", got_cyc_q[0], rd_cyc_q[0] + 2);
            check("t1_b2b_1", got_cyc_q[1], got_cyc_q[0] + 1);
            check("t1_b2b_2", got_cyc_q[2], got_cyc_q[0] + 2);
        end
        tick();
        tick();
        check("t1_valid_drop", 32'(bus.m_valid), 32'd0);

        // Reset while a pop is being issued.
        for (int i = 0; i < 10; i++) push_word(W'(i + 3));
        s = 0;
        while (!bus.fifo_rd_en && s < 20) begin
            tick();
            s++;
        end
        check("t2_rd_seen", 32'(bus.fifo_rd_en), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("t2_async_valid", 32'(bus.m_valid), 32'd0);
        check("t2_async_data", 32'(bus.m_data), 32'd0);
        check("t2_async_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        fifo_q.delete();
        pend_q.delete();
        bus.fifo_empty = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Full fifo of 256 words, counting down from 31 with wrap.
        got_q.delete();
        got_cyc_q.delete();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 256; i++) push_word(W'(31 - i));
        wait_got(256, 400, "t3_timeout");
        if (got_q.size() >= 256) begin
            check("t3_first", 32'(got_q[0]), 32'd31);
            check("t3_last", 32'(got_q[255]), 32'd0);
            gaps = 0;
            for (int i = 1; i < 256; i++) if (got_cyc_q[i] != got_cyc_q[i-1] + 1) gaps++;
            check("t3_gaps", gaps, 32'd0);
        end
        tick();
`ifdef FIFO_READER_CNT_EN
        check("t3_rd_count", rd_count, 32'd256);
`endif

        // Backpressure for 5 cycles mid-stream.
        got_q.delete();
        for (int i = 0; i < 20; i++) push_word(W'(i));
        wait_got(3, 30, "t4_start");
        bus.m_ready = 1'b0;
        s = rd_cyc_q.size();
        sd = bus.m_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold", 32'(bus.m_data), 32'(sd));
        end
        check("t4_extra_pops", 32'(rd_cyc_q.size() - s <= 1), 32'd1);
        check("t4_state", 32'(dbg_state), 32'(ST_TWO));
        bus.m_ready = 1'b1;
        wait_got(20, 60, "t4_resume");
        if (got_q.size() >= 20) check("t4_last", 32'(got_q[19]), 32'd19);
        wait_idle(20);

        // Flush with both slots full.
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 10; i++) push_word(W'(i));
        for (int i = 0; i < 6; i++) tick();
        check("t5_state", 32'(dbg_state), 32'(ST_TWO));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_flushed", 32'(bus.m_valid), 32'd0);
        base = got_q.size();
        bus.m_ready = 1'b1;
        wait_got(base + 1, 20, "t5_timeout");
        if (got_q.size() > base) check("t5_next", 32'(got_q[base]), 32'd3);
        wait_idle(40);

        // Flush while streaming, with a word in flight.
        for (int i = 11; i <= 16; i++) push_word(W'(i));
        base = got_q.size();
        wait_got(base + 1, 20, "t6_start");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_idle(40);

        // Upstream permanently empty.
        s = rd_cyc_q.size();
        for (int i = 0; i < 40; i++) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        check("t7_no_pops", rd_cyc_q.size() - s, 32'd0);
        check("t7_valid", 32'(bus.m_valid), 32'd0);

        // Random traffic, backpressure and flushes.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 1) == 0) push_word(W'($urandom_range(0, 31)));
            bus.m_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 49) == 0);
            tick();
        end
        flush = 1'b0;
        bus.m_ready = 1'b1;
        wait_idle(2000);
        tick();
        tick();
        check("end_valid", 32'(bus.m_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
